draw_banner_anim: RTL and testbench

- Parametrised successor to the fixed-size game-over overlay: draws one of N_BANNERS same-size sprite banners over the VGA stream.
- Slides the selected banner down from the top edge to screen centre, one step per frame, then holds it.
- Sprite ROM is external: the block drives the address and takes pixel data back after a fixed latency.
- Output feeds the overlay mux downstream of the game renderer.

---
 rtl/draw_banner_anim_if.sv | 22 ++
 rtl/draw_banner_anim.sv | 231 +++++++++++++++++++++++
 tb/tb_draw_banner_anim.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_banner_anim_if.sv
// ---------------------------------------------------------------------------
// vga_if : VGA timing stream shared between the timing generator, the game
// renderer and the overlay blocks.
//
//   hcount  11  horizontal pixel counter (0 .. total width - 1)
//   vcount  11  vertical line counter   (0 .. total height - 1)
//   vsync   1   vertical sync pulse
//
// Modports:
//   master  timing source, drives all signals
//   slave   generic consumer, reads all signals
//   in      consumer view used by the overlay blocks (same shape as slave)
// ---------------------------------------------------------------------------
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        vsync;

    modport master (output hcount, output vcount, output vsync);
    modport slave  (input  hcount, input  vcount, input  vsync);
    modport in     (input  hcount, input  vcount, input  vsync);
endinterface

// File: rtl/draw_banner_anim.sv
// ---------------------------------------------------------------------------
// draw_banner_anim : draws one of N_BANNERS equal-size sprite banners over
// the VGA stream. The selected banner slides down from the top edge towards
// the vertical screen centre by SLIDE_STEP pixels per frame, then holds.
// Pixel data comes from an external sprite ROM with ROM_LAT cycles latency.
//
// Ports:
//   clk       pixel clock
//   rst       synchronous, active-high reset
//   start     one-cycle pulse that begins the animation (ignored while busy)
//   sel       banner index, sampled on start, clamped to N_BANNERS-1
//   clear     abort/hide, back to IDLE next cycle (wins over start)
//   vin       timing stream (hcount, vcount, vsync)
//   rom_addr  registered sprite ROM address (0 outside the banner box)
//   rom_data  ROM pixel, valid ROM_LAT cycles after rom_addr
//   rgb       overlay pixel (0 when not valid)
//   valid     overlay pixel is opaque and must be drawn
//   busy      high while sliding or showing
//
// Latency from vin sample to rgb/valid is ROM_LAT+1 cycles; the caller
// delays its own copy of vin to match.
//
// Optional feature macro: BANNER_BLINK_EN. When defined, the banner blinks
// in SHOW with a half-period of BLINK_FRAMES frames, starting visible.
// When undefined the banner is always visible and no counter is built.
// ---------------------------------------------------------------------------
module draw_banner_anim #(
    parameter int          SCREEN_W     = 1024,
    parameter int          SCREEN_H     = 768,
    parameter int          BAN_W        = 201,
    parameter int          BAN_H        = 56,
    parameter int          N_BANNERS    = 3,
    parameter int          ADDR_W       = 16,
    parameter int          ROM_LAT      = 1,
    parameter int          SLIDE_STEP   = 8,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F,
    parameter int          BLINK_FRAMES = 30,
    // A single banner still needs a one-bit select port.
    localparam int         SEL_W        = (N_BANNERS > 1) ? $clog2(N_BANNERS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic              clear,
    vga_if.in                 vin,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [11:0]       rgb,
    output logic              valid,
    output logic              busy
);

    localparam int AW2 = ADDR_W + 2;

    localparam logic [11:0]      X0_C     = 12'((SCREEN_W - BAN_W) / 2);
    localparam logic [11:0]      X1_C     = 12'((SCREEN_W - BAN_W) / 2 + BAN_W);
    localparam logic [10:0]      TARGET_Y = 11'((SCREEN_H - BAN_H) / 2);
    localparam logic [11:0]      STEP_C   = 12'(SLIDE_STEP);
    localparam logic [11:0]      BAN_H_C  = 12'(BAN_H);
    localparam logic [AW2-1:0]   BAN_W_A  = AW2'(BAN_W);
    localparam logic [AW2-1:0]   BAN_SZ_A = AW2'(BAN_W * BAN_H);
    localparam logic [SEL_W:0]   N_BAN_C  = (SEL_W + 1)'(N_BANNERS);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_BANNERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLIDE = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [10:0]       cur_y, cur_y_n;
    logic [SEL_W-1:0]  sel_q, sel_q_n;
    logic              vsync_q;
    logic              frame_tick;
    logic              draw_en;
    logic              in_box;
    logic [AW2-1:0]    addr_full;
    logic [10:0]       dx, dy;
    logic [11:0]       slide_sum;
    logic [ROM_LAT:0]  box_pipe;
    logic [ROM_LAT:0]  en_pipe;

    // Rising edge of the registered vsync; cur_y only moves on this pulse,
    // which falls in vertical blanking, so a frame never tears.
    assign frame_tick = vin.vsync & ~vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vin.vsync;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur_y <= '0;
            sel_q <= '0;
        end else begin
            state <= state_n;
            cur_y <= cur_y_n;
            sel_q <= sel_q_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cur_y_n   = cur_y;
        sel_q_n   = sel_q;
        slide_sum = {1'b0, cur_y} + STEP_C;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q_n = ({1'b0, sel} >= N_BAN_C) ? SEL_MAX : sel;
                        cur_y_n = '0;
                        state_n = SLIDE;
                    end
                end
                SLIDE: begin
                    if (frame_tick) begin
                        if (slide_sum >= {1'b0, TARGET_Y}) begin
                            cur_y_n = TARGET_Y;
                            state_n = SHOW;
                        end else begin
                            cur_y_n = slide_sum[10:0];
                        end
                    end
                end
                SHOW: begin
                    state_n = SHOW;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Draw enable
    // ------------------------------------------------------------------
`ifdef BANNER_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;

    // Counter sits at "visible, count 0" everywhere except SHOW, so every
    // entry into SHOW starts with a full visible half-period.
    always_ff @(posedge clk) begin
        if (rst || state != SHOW) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign draw_en = (state == SLIDE) || ((state == SHOW) && blink_on);
`else
    logic blink_unused;
    assign blink_unused = (BLINK_FRAMES > 0);
    assign draw_en      = (state != IDLE);
`endif

    // ------------------------------------------------------------------
    // Stage 0: box test and ROM address
    // ------------------------------------------------------------------
    always_comb begin
        in_box = (state != IDLE)
              && ({1'b0, vin.hcount} >= X0_C)
              && ({1'b0, vin.hcount} <  X1_C)
              && ({1'b0, vin.vcount} >= {1'b0, cur_y})
              && ({1'b0, vin.vcount} <  ({1'b0, cur_y} + BAN_H_C));
        dx = vin.hcount - X0_C[10:0];
        dy = vin.vcount - cur_y;
        // Widened by two bits so intermediate sums cannot wrap before the
        // final truncation to the ROM address width.
        addr_full = AW2'(sel_q) * BAN_SZ_A + AW2'(dy) * BAN_W_A + AW2'(dx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= in_box ? ADDR_W'(addr_full) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Align box/enable with rom_data: one stage for the address register
    // plus ROM_LAT stages for the ROM itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            box_pipe <= '0;
            en_pipe  <= '0;
        end else begin
            box_pipe[0] <= in_box;
            en_pipe[0]  <= draw_en;
            for (int i = 1; i <= ROM_LAT; i++) begin
                box_pipe[i] <= box_pipe[i-1];
                en_pipe[i]  <= en_pipe[i-1];
            end
        end
    end

    assign valid = box_pipe[ROM_LAT] & en_pipe[ROM_LAT] & (rom_data != KEY_COLOR);
    assign rgb   = valid ? rom_data : 12'h000;

endmodule

// File: tb/tb_draw_banner_anim.sv
// ---------------------------------------------------------------------------
// Bench for draw_banner_anim at its default geometry. The raster is not
// swept in full: frame ticks are short vsync pulses and only the lines and
// columns of interest around the banner are driven. A reference model of
// the animation pushes expected {valid, rgb} and rom_addr values into queues
// as each pixel is driven; they are popped when the pipeline delivers them.
// ---------------------------------------------------------------------------
module tb_draw_banner_anim;

    localparam int          SCREEN_W     = 1024;
    localparam int          SCREEN_H     = 768;
    localparam int          BAN_W        = 201;
    localparam int          BAN_H        = 56;
    localparam int          N_BANNERS    = 3;
    localparam int          ADDR_W       = 16;
    localparam int          ROM_LAT      = 1;
    localparam int          SLIDE_STEP   = 8;
    localparam logic [11:0] KEY_COLOR    = 12'hF0F;
    localparam int          BLINK_FRAMES = 30;

    localparam int X0       = (SCREEN_W - BAN_W) / 2;
    localparam int TARGET_Y = (SCREEN_H - BAN_H) / 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start;
    logic [1:0]        sel;
    logic              clear;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [11:0]       rgb;
    logic              valid;
    logic              busy;

    vga_if vin ();

    draw_banner_anim #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BAN_W(BAN_W), .BAN_H(BAN_H),
        .N_BANNERS(N_BANNERS), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT),
        .SLIDE_STEP(SLIDE_STEP), .KEY_COLOR(KEY_COLOR), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .clear(clear),
        .vin(vin), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .valid(valid), .busy(busy)
    );

    // ---------------- external ROM model ----------------
    int key_addr = -1;

    function automatic logic [11:0] rom_fn(input logic [ADDR_W-1:0] a);
        if (int'(a) == key_addr) return KEY_COLOR;
        return {1'b0, a[10:0]};
    endfunction

    logic [11:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] <= 12'h000;
        end else begin
            rom_pipe[0] <= rom_fn(rom_addr);
            for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // ---------------- scoreboard ----------------
    logic [12:0]       exp_q  [$];
    logic [ADDR_W-1:0] addr_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state = 0;   // 0 idle, 1 slide, 2 show
    int m_y     = 0;
    int m_sel   = 0;
    bit m_prev_vs = 1'b0;
    int m_cnt   = 0;
    bit m_on    = 1'b1;

    // One pixel clock: check what is due, drive the new pixel, predict it.
    task automatic cyc(input int h, input int v, input bit vs,
                       input bit st, input int sl, input bit cl);
        logic [12:0]       e;
        bit                box, de, vld, tick;
        int                a;
        logic [ADDR_W-1:0] a16;
        logic [11:0]       d;
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_state != 0));
        if (addr_q.size() == 1) check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
        if (exp_q.size() == ROM_LAT + 1) begin
            e = exp_q.pop_front();
            check("valid", 32'(valid), 32'(e[12]));
            check("rgb", 32'(rgb), 32'(e[11:0]));
        end
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.vsync  = vs;
        start      = st;
        sel        = 2'(sl);
        clear      = cl;

        box = (m_state != 0) && (h >= X0) && (h < X0 + BAN_W) &&
              (v >= m_y) && (v < m_y + BAN_H);
`ifdef BANNER_BLINK_EN
        de = (m_state == 1) || (m_state == 2 && m_on);
`else
        de = 1'b1;
`endif
        a   = box ? (m_sel * BAN_W * BAN_H + (v - m_y) * BAN_W + (h - X0)) % (1 << ADDR_W) : 0;
        a16 = ADDR_W'(a);
        d   = rom_fn(a16);
        vld = box && de && (d != KEY_COLOR);
        addr_q.push_back(a16);
        exp_q.push_back({vld, vld ? d : 12'h000});

        tick = vs && !m_prev_vs;
        if (m_state != 2) begin
            m_cnt = 0;
            m_on  = 1'b1;
        end else if (tick) begin
            if (m_cnt == BLINK_FRAMES - 1) begin
                m_cnt = 0;
                m_on  = !m_on;
            end else begin
                m_cnt++;
            end
        end
        if (cl) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (st) begin
                m_sel   = (sl >= N_BANNERS) ? N_BANNERS - 1 : sl;
                m_y     = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (tick) begin
                if (m_y + SLIDE_STEP >= TARGET_Y) begin
                    m_y     = TARGET_Y;
                    m_state = 2;
                end else begin
                    m_y += SLIDE_STEP;
                end
            end
        end
        m_prev_vs = vs;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame_tick();
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic probe(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cyc(h, v, 0, 0, 0, 0);
    endtask

    task automatic probe_edges();
        probe(m_y, X0 - 2, X0 + 3);
        probe(m_y + BAN_H - 1, X0 + BAN_W - 4, X0 + BAN_W + 1);
        probe(m_y + BAN_H, X0 - 1, X0 + 2);
        for (int i = 0; i < 4; i++)
            cyc($urandom_range(X0 - 10, X0 + BAN_W + 10),
                m_y + $urandom_range(0, BAN_H + 2), 0, 0, 0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        vin.hcount = '0;
        vin.vcount = '0;
        vin.vsync  = 1'b0;
        start = 1'b0;
        sel   = '0;
        clear = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);

        // Idle frames: nothing drawn anywhere near the banner area.
        frame_tick();
        probe(0, X0 - 2, X0 + BAN_W + 1);
        probe(TARGET_Y, X0 - 2, X0 + BAN_W + 1);
        frame_tick();
        probe(TARGET_Y + BAN_H - 1, X0 - 2, X0 + BAN_W + 1);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, SCREEN_W - 1), $urandom_range(0, SCREEN_H - 1), 0, 0, 0, 0);

        // Start banner 1: visible at the top edge before the first tick.
        cyc(0, 0, 0, 1, 1, 0);
        probe_edges();

        // Slide down to the centre and a couple of frames of holding.
        for (int k = 1; k <= 47; k++) begin
            frame_tick();
            probe_edges();
        end

        // Full box scan in SHOW with one key-coloured pixel.
        key_addr = 1 * BAN_W * BAN_H + 3 * BAN_W + 5;
        for (int v = TARGET_Y - 1; v <= TARGET_Y + BAN_H; v++) probe(v, X0 - 1, X0 + BAN_W);
        idle(ROM_LAT + 2);
        key_addr = -1;

        // Long hold in SHOW (covers blink half-periods when enabled).
        for (int k = 0; k < 65; k++) begin
            frame_tick();
            probe(m_y, X0 - 1, X0 + 4);
        end

        // clear together with start during SHOW: clear wins.
        cyc(0, 0, 0, 1, 2, 1);
        probe(TARGET_Y, X0 - 1, X0 + 4);
        frame_tick();
        probe(0, X0 - 1, X0 + 4);

        // Restart from the top with banner 0, then clear mid-line.
        cyc(0, 0, 0, 1, 0, 0);
        for (int h = X0 - 2; h < X0 + 20; h++) cyc(h, 0, 0, 0, 0, h == X0 + 8);
        probe(0, X0 + 20, X0 + 24);

        // Out-of-range select clamps to the last banner.
        cyc(0, 0, 0, 1, 3, 0);
        probe_edges();
        frame_tick();
        probe_edges();
        frame_tick();
        probe_edges();

        idle(ROM_LAT + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
